// File: rtl/adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// adc_trigger_capture
//
// Capture-control stage in the ADC write-clock domain, sitting in front of the
// DataStorage FIFO. Each clock carries one 32-bit word of four 8-bit samples
// ([31:24] oldest, [7:0] newest). The block waits for a threshold crossing,
// then streams a programmed number of words into the FIFO, drops words while
// the FIFO is full (flagging Overflow) and pulses Done at the end.
//
// Optional feature: define TRIGGER_TIMEOUT_EN to force a trigger after
// TIMEOUT_CYCLES consecutive ARMED cycles without a crossing (TimedOut flags
// it). Without the macro ARMED waits indefinitely and TimedOut stays 0.
//
// WriteStrobe is deliberately combinational from the state register and
// FifoNotFull: the FIFO's full indication is honoured in the very cycle of
// the write, with no look-ahead. Every other output is a flop.
// ---------------------------------------------------------------------------
module adc_trigger_capture #(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [31:0]            DataIn,
    input  logic                   Arm,
    input  logic                   Abort,
    input  logic [7:0]             Threshold,
    input  logic                   Slope,
    input  logic [COUNT_WIDTH-1:0] RecordLength,
    input  logic                   FifoNotFull,
    output logic [31:0]            DataOut,
    output logic                   WriteStrobe,
    output logic [1:0]             State,
    output logic                   Triggered,
    output logic                   Done,
    output logic                   Overflow,
    output logic                   TimedOut
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] RECORD = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1'b1);
    localparam logic [COUNT_WIDTH-1:0] ZERO_COUNT = {COUNT_WIDTH{1'b0}};

    // A crossing exists between consecutive samples i-1 and i when their
    // "below threshold" flags differ in the direction selected by rising.
    // below[0] is the previous word's newest sample, below[4] this word's.
    function automatic logic crossingHit(input logic [4:0] below, input logic rising);
        logic [3:0] edges;
        if (rising) begin
            edges = below[3:0] & ~below[4:1];
        end else begin
            edges = ~below[3:0] & below[4:1];
        end
        return |edges;
    endfunction

    logic [1:0]             fsmState_r;
    logic [1:0]             nextState_s;
    logic [31:0]            dataOut_r;
    logic [7:0]             prevSample_r;
    logic [COUNT_WIDTH-1:0] lengthLatched_r;
    logic [COUNT_WIDTH-1:0] remaining_r;
    logic                   triggered_r;
    logic                   done_r;
    logic                   overflow_r;
    logic                   timedOut_r;
    logic [4:0]             belowThreshold_s;
    logic                   hit_s;
    logic                   trigger_s;
    logic                   timeoutOnly_s;
    logic                   armAccepted_s;

    // Per-sample below-threshold flags across the five-sample window and the crossing test
    always_comb begin
        belowThreshold_s[0] = (prevSample_r   < Threshold);
        belowThreshold_s[1] = (DataIn[31:24]  < Threshold);
        belowThreshold_s[2] = (DataIn[23:16]  < Threshold);
        belowThreshold_s[3] = (DataIn[15:8]   < Threshold);
        belowThreshold_s[4] = (DataIn[7:0]    < Threshold);
        hit_s               = crossingHit(belowThreshold_s, Slope);
    end

`ifdef TRIGGER_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ONE  = TIMEOUT_W'(1'b1);

    logic [TIMEOUT_W-1:0] timeoutCount_r;
    logic                 timeoutFire_s;

    // The timeout fires on the TIMEOUT_CYCLES-th consecutive ARMED cycle
    always_comb begin
        timeoutFire_s = (fsmState_r == ARMED) && (timeoutCount_r == TIMEOUT_LAST);
        trigger_s     = (fsmState_r == ARMED) && (hit_s || timeoutFire_s);
        timeoutOnly_s = timeoutFire_s && !hit_s;
    end

    // Count consecutive ARMED cycles; any exit from ARMED restarts the count
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            timeoutCount_r <= {TIMEOUT_W{1'b0}};
        end else if ((fsmState_r == ARMED) && (nextState_s == ARMED)) begin
            timeoutCount_r <= timeoutCount_r + TIMEOUT_ONE;
        end else begin
            timeoutCount_r <= {TIMEOUT_W{1'b0}};
        end
    end
`else
    logic unusedTimeoutCfg_s;

    // Without the timeout only a real crossing can trigger
    always_comb begin
        trigger_s          = (fsmState_r == ARMED) && hit_s;
        timeoutOnly_s      = 1'b0;
        unusedTimeoutCfg_s = (TIMEOUT_CYCLES > 0);
    end
`endif

    // Next-state decode; Abort overrides every transition
    always_comb begin
        nextState_s = fsmState_r;
        if (Abort) begin
            nextState_s = IDLE;
        end else begin
            case (fsmState_r)
                IDLE: begin
                    if (Arm) begin
                        nextState_s = ARMED;
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                ARMED: begin
                    if (trigger_s) begin
                        nextState_s = RECORD;
                    end else begin
                        nextState_s = ARMED;
                    end
                end
                RECORD: begin
                    if (remaining_r == ONE_COUNT) begin
                        nextState_s = DONE;
                    end else begin
                        nextState_s = RECORD;
                    end
                end
                DONE: begin
                    nextState_s = IDLE;
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end
    end

    // An Arm is only honoured from IDLE and never together with Abort
    always_comb begin
        armAccepted_s = (fsmState_r == IDLE) && Arm && !Abort;
    end

    // Data path: output word and previous-sample register follow DataIn every cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dataOut_r    <= 32'h0000_0000;
            prevSample_r <= 8'h00;
        end else begin
            dataOut_r    <= DataIn;
            prevSample_r <= DataIn[7:0];
        end
    end

    // State register and the Done pulse, which marks the single DONE cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fsmState_r <= IDLE;
            done_r     <= 1'b0;
        end else begin
            fsmState_r <= nextState_s;
            done_r     <= (nextState_s == DONE);
        end
    end

    // Record length latch and the per-record word countdown
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lengthLatched_r <= ZERO_COUNT;
            remaining_r     <= ZERO_COUNT;
        end else begin
            if (armAccepted_s) begin
                // A zero length still records the trigger word
                lengthLatched_r <= (RecordLength == ZERO_COUNT) ? ONE_COUNT : RecordLength;
            end
            if (trigger_s && !Abort) begin
                remaining_r <= lengthLatched_r;
            end else if (fsmState_r == RECORD) begin
                // Dropped words consume a slot too: time never stalls
                remaining_r <= remaining_r - ONE_COUNT;
            end
        end
    end

    // Status flags: cleared by an accepted Arm, otherwise they only ever set
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
            timedOut_r  <= 1'b0;
        end else if (armAccepted_s) begin
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
            timedOut_r  <= 1'b0;
        end else begin
            if (trigger_s && !Abort) begin
                triggered_r <= 1'b1;
                timedOut_r  <= timeoutOnly_s;
            end
            if ((fsmState_r == RECORD) && !FifoNotFull) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output mapping; the strobe reacts to FifoNotFull within the same cycle
    always_comb begin
        DataOut     = dataOut_r;
        WriteStrobe = (fsmState_r == RECORD) && FifoNotFull;
        State       = fsmState_r;
        Triggered   = triggered_r;
        Done        = done_r;
        Overflow    = overflow_r;
        TimedOut    = timedOut_r;
    end

    adc_trigger_capture_checker u_checker (
        .Clock       (Clock),
        .Reset       (Reset),
        .Abort       (Abort),
        .State       (State),
        .WriteStrobe (WriteStrobe),
        .Done        (Done)
    );

endmodule

// ---------------------------------------------------------------------------
// Protocol properties of adc_trigger_capture, kept apart from the design.
// ---------------------------------------------------------------------------
module adc_trigger_capture_checker (
    input logic       Clock,
    input logic       Reset,
    input logic       Abort,
    input logic [1:0] State,
    input logic       WriteStrobe,
    input logic       Done
);

    // Writes only happen while recording
    assert property (@(posedge Clock) disable iff (!Reset) WriteStrobe |-> (State == 2'd2));

    // Done is exactly the DONE state
    assert property (@(posedge Clock) disable iff (!Reset) Done == (State == 2'd3));

    // Done lasts one cycle and is followed by IDLE
    assert property (@(posedge Clock) disable iff (!Reset) Done |=> (State == 2'd0));

    // Abort always lands in IDLE
    assert property (@(posedge Clock) disable iff (!Reset) Abort |=> (State == 2'd0));

endmodule

// File: tb/tb_adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// Self-checking bench for adc_trigger_capture. Expected FIFO words are pushed
// to a scoreboard queue as the stimulus is driven; a negedge monitor pops and
// compares them whenever WriteStrobe is observed.
// ---------------------------------------------------------------------------
module tb_adc_trigger_capture;

    localparam int CW = 16;

    logic          Clock;
    logic          Reset;
    logic [31:0]   DataIn;
    logic          Arm;
    logic          Abort;
    logic [7:0]    Threshold;
    logic          Slope;
    logic [CW-1:0] RecordLength;
    logic          FifoNotFull;
    logic [31:0]   DataOut;
    logic          WriteStrobe;
    logic [1:0]    State;
    logic          Triggered;
    logic          Done;
    logic          Overflow;
    logic          TimedOut;

    int          checks = 0;
    int          errors = 0;
    int          strobeCount = 0;
    logic [31:0] expQ[$];

    adc_trigger_capture #(
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .DataIn       (DataIn),
        .Arm          (Arm),
        .Abort        (Abort),
        .Threshold    (Threshold),
        .Slope        (Slope),
        .RecordLength (RecordLength),
        .FifoNotFull  (FifoNotFull),
        .DataOut      (DataOut),
        .WriteStrobe  (WriteStrobe),
        .State        (State),
        .Triggered    (Triggered),
        .Done         (Done),
        .Overflow     (Overflow),
        .TimedOut     (TimedOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every observed write must match the next expected word
    always @(negedge Clock) begin
        if (Reset && WriteStrobe) begin
            strobeCount++;
            if (expQ.size() > 0) begin
                checkEq("dataOut", DataOut, expQ.pop_front());
            end else begin
                checkEq("sbDepth", 32'(expQ.size()), 32'd1);
            end
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic armWith(input logic [CW-1:0] len);
        RecordLength = len;
        Arm = 1'b1;
        tick;
        Arm = 1'b0;
        checkEq("armState", 32'(State), 32'd1);
        checkEq("armFlags", 32'({Triggered, Overflow, TimedOut}), 32'd0);
    endtask

    // Drive the trigger word from ARMED, then len RECORD cycles; dropMask bit j
    // holds the FIFO full during RECORD cycle j+1.
    task automatic recordRun(input logic [31:0] trigWord, input int len, input logic [15:0] dropMask);
        logic [31:0] w;
        int expStrobes;
        w = trigWord;
        expStrobes = 0;
        strobeCount = 0;
        DataIn = w;
        tick;
        for (int j = 0; j < len; j++) begin
            FifoNotFull = ~dropMask[j];
            if (!dropMask[j]) begin
                expQ.push_back(w);
                expStrobes++;
            end
            checkEq("recState", 32'(State), 32'd2);
            w = w + 32'h0101_0101;
            DataIn = w;
            tick;
        end
        FifoNotFull = 1'b1;
        checkEq("doneState", 32'(State), 32'd3);
        checkEq("donePulse", 32'(Done), 32'd1);
        checkEq("triggered", 32'(Triggered), 32'd1);
        tick;
        checkEq("idleState", 32'(State), 32'd0);
        checkEq("doneLow", 32'(Done), 32'd0);
        checkEq("strobes", 32'(strobeCount), 32'(expStrobes));
        checkEq("sbEmpty", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int n;
        Reset        = 1'b0;
        DataIn       = 32'h0;
        Arm          = 1'b0;
        Abort        = 1'b0;
        Threshold    = 8'h80;
        Slope        = 1'b1;
        RecordLength = 16'd4;
        FifoNotFull  = 1'b1;

        // Reset values
        tick;
        checkEq("rstData", DataOut, 32'h0);
        checkEq("rstCtl", 32'({WriteStrobe, State, Triggered, Done, Overflow, TimedOut}), 32'd0);
        Reset = 1'b1;
        tick;

        // Rising trigger inside a word, length 4
        DataIn = 32'h0;
        armWith(16'd4);
        DataIn = 32'h1010_1010;
        tick;
        checkEq("noTrigLow", 32'(State), 32'd1);
        recordRun(32'h1010_9010, 4, 16'h0000);

        // Rising crossing across the word boundary (prev 0x7F -> 0x81)
        DataIn = 32'h0;
        armWith(16'd1);
        DataIn = 32'h0000_007F;
        tick;
        checkEq("noTrig7F", 32'(State), 32'd1);
        recordRun(32'h8100_0000, 1, 16'h0000);

        // Sample exactly at threshold counts as reached
        DataIn = 32'h0;
        armWith(16'd2);
        DataIn = 32'h7F7F_7F7F;
        tick;
        checkEq("noTrigBelow", 32'(State), 32'd1);
        recordRun(32'h7F7F_7F80, 2, 16'h0000);

        // Falling crossing across the word boundary (prev 0x90 -> 0x10)
        Slope  = 1'b0;
        DataIn = 32'h9090_9090;
        armWith(16'd1);
        DataIn = 32'h9090_9090;
        tick;
        checkEq("noTrigHigh", 32'(State), 32'd1);
        recordRun(32'h10FF_FFFF, 1, 16'h0000);

        // FIFO full in RECORD cycles 3 and 4 of an 8-word record
        Slope  = 1'b1;
        DataIn = 32'h0;
        armWith(16'd8);
        recordRun(32'h0000_0090, 8, 16'h000C);
        checkEq("overflowSet", 32'(Overflow), 32'd1);

        // Next Arm clears Overflow; Abort in the 2nd (and last) RECORD cycle
        DataIn = 32'h0;
        armWith(16'd2);
        strobeCount = 0;
        DataIn = 32'h0000_00A0;
        tick;
        expQ.push_back(32'h0000_00A0);
        checkEq("abRec1", 32'(State), 32'd2);
        DataIn = 32'h1234_5678;
        tick;
        expQ.push_back(32'h1234_5678);
        checkEq("abRec2", 32'(State), 32'd2);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        checkEq("abortIdle", 32'(State), 32'd0);
        checkEq("abortNoDone", 32'(Done), 32'd0);
        checkEq("abortStrobes", 32'(strobeCount), 32'd2);
        checkEq("abortTrigKept", 32'(Triggered), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkEq("abortQuiet", 32'({State, Done}), 32'd0);
        end

        // Arm together with Abort is not accepted
        Arm   = 1'b1;
        Abort = 1'b1;
        tick;
        Arm   = 1'b0;
        Abort = 1'b0;
        checkEq("armAbortIdle", 32'(State), 32'd0);
        checkEq("armAbortFlags", 32'(Triggered), 32'd1);

        // Asynchronous reset in the middle of a record
        DataIn = 32'h0;
        armWith(16'd5);
        strobeCount = 0;
        DataIn = 32'h0000_00C0;
        tick;
        expQ.push_back(32'h0000_00C0);
        DataIn = 32'h0000_0001;
        tick;
        Reset = 1'b0;
        #1;
        checkEq("midRstData", DataOut, 32'h0);
        checkEq("midRstCtl", 32'({WriteStrobe, State, Triggered, Done, Overflow, TimedOut}), 32'd0);
        checkEq("midRstStrobes", 32'(strobeCount), 32'd1);
        #2;
        Reset = 1'b1;
        tick;
        checkEq("postRstIdle", 32'({State, Done}), 32'd0);

        // RecordLength 0 still records exactly one word
        DataIn = 32'h0;
        armWith(16'd0);
        recordRun(32'h0000_00FF, 1, 16'h0000);

`ifdef TRIGGER_TIMEOUT_EN
        // Constant input: forced trigger after 20 ARMED cycles
        DataIn = 32'h0;
        armWith(16'd1);
        strobeCount = 0;
        expQ.push_back(32'h0);
        n = 0;
        while (State != 2'd2 && n < 100) begin
            tick;
            n++;
        end
        checkEq("timeoutDelay", 32'(n), 32'd20);
        checkEq("timedOutSet", 32'(TimedOut), 32'd1);
        tick;
        checkEq("timeoutDone", 32'(Done), 32'd1);
        tick;
        checkEq("timeoutIdle", 32'(State), 32'd0);
        checkEq("timeoutStrobes", 32'(strobeCount), 32'd1);
`else
        // Without the timeout ARMED waits indefinitely
        DataIn = 32'h0;
        armWith(16'd1);
        n = 0;
        while (n < 1000) begin
            tick;
            n++;
        end
        checkEq("stillArmed", 32'(State), 32'd1);
        checkEq("timedOutTied", 32'(TimedOut), 32'd0);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        checkEq("armedAbort", 32'(State), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
